// File: rtl/rx_crc_checker_pkg.sv
// Shared constants and types for the receive-side CRC checking stage.
package rx_crc_checker_pkg;

  localparam logic [31:0] CRC32_POLY = 32'h04C11DB7;
  localparam logic [31:0] CRC32_INIT = 32'hFFFFFFFF;

  // Bit position of the payload-length field inside the header word.
  localparam int unsigned HDR_LEN_LSB = 0;

  typedef enum logic [1:0] {
    HEADER,
    PAYLOAD,
    TRAILER
  } crc_state_e;

endpackage

// File: rtl/rx_crc_checker_if.sv
// Valid/ready word stream between pipeline stages of the endpoint receive path.
interface rx_crc_checker_if;
  logic        valid;
  logic        ready;
  logic [31:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/rx_crc_checker_crc32_word.sv
// One full 32-bit CRC-32/MPEG-2 update per call, data consumed MSB first.
module crc32_word
  import rx_crc_checker_pkg::*;
(
  input  logic [31:0] crc_in,
  input  logic [31:0] data,
  output logic [31:0] crc_out
);

  logic [31:0] acc;

  // Unrolled bit-serial LFSR: 32 shift steps collapse into one XOR network.
  always_comb begin
    acc = crc_in;
    for (int unsigned i = 0; i < 32; i++) begin
      if (acc[31] ^ data[5'(31 - i)]) begin
        acc = {acc[30:0], 1'b0} ^ CRC32_POLY;
      end else begin
        acc = {acc[30:0], 1'b0};
      end
    end
    crc_out = acc;
  end

endmodule

// File: rtl/rx_crc_checker.sv
// Receive integrity stage: forwards header/payload, strips and checks the CRC trailer.
module rx_crc_checker
  import rx_crc_checker_pkg::*;
#(
  parameter int unsigned LEN_BITS  = 7,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 n_rst,
  rx_crc_checker_if.slave      in_bus,
  rx_crc_checker_if.master     out_bus,
  output logic                 out_last,
  output logic                 crc_valid,
  output logic                 crc_error,
  input  logic                 cnt_clear,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] err_count
);

  crc_state_e           state, state_next;
  logic [31:0]          crc, crc_next;
  logic [31:0]          crc_seed, crc_upd;
  logic [LEN_BITS-1:0]  remaining, remaining_next;
  logic [LEN_BITS-1:0]  hdr_len;
  logic                 trailer_hs;
  logic                 mismatch;
  logic [CNT_WIDTH-1:0] pkt_cnt, pkt_next;
  logic [CNT_WIDTH-1:0] err_cnt, err_next;

  assign hdr_len  = in_bus.data[HDR_LEN_LSB +: LEN_BITS];
  // A header always re-seeds the CRC, so the seed is chosen outside the FSM block.
  assign crc_seed = (state == HEADER) ? CRC32_INIT : crc;
  assign mismatch = (in_bus.data != crc);

  crc32_word u_crc32_word (
    .crc_in  (crc_seed),
    .data    (in_bus.data),
    .crc_out (crc_upd)
  );

  // FSM state, running CRC and remaining payload words.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= HEADER;
      crc       <= CRC32_INIT;
      remaining <= '0;
    end else begin
      state     <= state_next;
      crc       <= crc_next;
      remaining <= remaining_next;
    end
  end

  // Next-state, pass-through handshake and trailer detection.
  always_comb begin
    state_next     = state;
    crc_next       = crc;
    remaining_next = remaining;
    in_bus.ready   = 1'b0;
    out_bus.valid  = 1'b0;
    out_bus.data   = in_bus.data;
    out_last       = 1'b0;
    trailer_hs     = 1'b0;
    case (state)
      HEADER: begin
        out_bus.valid = in_bus.valid;
        in_bus.ready  = out_bus.ready;
        out_last      = (hdr_len == '0);
        if (in_bus.valid && out_bus.ready) begin
          crc_next       = crc_upd;
          remaining_next = hdr_len;
          state_next     = (hdr_len == '0) ? TRAILER : PAYLOAD;
        end
      end
      PAYLOAD: begin
        out_bus.valid = in_bus.valid;
        in_bus.ready  = out_bus.ready;
        out_last      = (remaining == LEN_BITS'(1));
        if (in_bus.valid && out_bus.ready) begin
          crc_next       = crc_upd;
          remaining_next = remaining - 1'b1;
          if (remaining == LEN_BITS'(1)) begin
            state_next = TRAILER;
          end
        end
      end
      TRAILER: begin
        in_bus.ready = 1'b1;
        if (in_bus.valid) begin
          trailer_hs = 1'b1;
          state_next = HEADER;
        end
      end
      default: state_next = HEADER;
    endcase
  end

  // Saturating counters; clear wins over a same-cycle increment.
  always_comb begin
    pkt_next = pkt_cnt;
    err_next = err_cnt;
    if (cnt_clear) begin
      pkt_next = '0;
      err_next = '0;
    end else if (trailer_hs) begin
      if (pkt_cnt != '1) begin
        pkt_next = pkt_cnt + 1'b1;
      end
      if (mismatch && (err_cnt != '1)) begin
        err_next = err_cnt + 1'b1;
      end
    end
  end

  // Verdict pulses and counter registers.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      crc_valid <= 1'b0;
      crc_error <= 1'b0;
      pkt_cnt   <= '0;
      err_cnt   <= '0;
    end else begin
      crc_valid <= trailer_hs && !mismatch;
      crc_error <= trailer_hs && mismatch;
      pkt_cnt   <= pkt_next;
      err_cnt   <= err_next;
    end
  end

  assign pkt_count = pkt_cnt;
  assign err_count = err_cnt;

endmodule

// File: tb/tb_rx_crc_checker.sv
// Randomized self-checking bench for rx_crc_checker against a stream-level model.
module tb_rx_crc_checker;
  import rx_crc_checker_pkg::*;

  typedef struct { logic [31:0] data; bit trailer; bit good; } word_t;
  typedef struct { logic [31:0] data; bit last; } fwd_t;

  logic        clk = 1'b0;
  logic        n_rst = 1'b0;
  logic        cnt_clear = 1'b0;
  logic        out_last, crc_valid, crc_error;
  logic [15:0] pkt_count, err_count;
  logic [31:0] w_crc, w_data, w_out;

  rx_crc_checker_if in_bus ();
  rx_crc_checker_if out_bus ();

  rx_crc_checker #(.LEN_BITS(7), .CNT_WIDTH(16)) dut (
    .clk       (clk),
    .n_rst     (n_rst),
    .in_bus    (in_bus),
    .out_bus   (out_bus),
    .out_last  (out_last),
    .crc_valid (crc_valid),
    .crc_error (crc_error),
    .cnt_clear (cnt_clear),
    .pkt_count (pkt_count),
    .err_count (err_count)
  );

  crc32_word u_word (.crc_in(w_crc), .data(w_data), .crc_out(w_out));

  always #5 clk = ~clk;

  int          n_vec = 0;
  int          n_bad = 0;
  word_t       stim_q[$];
  fwd_t        exp_fwd[$];
  logic [31:0] pay_q[$];
  bit          pend_good = 1'b0;
  bit          pend_bad = 1'b0;
  logic [15:0] m_pkt = '0;
  logic [15:0] m_err = '0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Remainder of a 64-bit polynomial modulo x^32 + POLY, by long division.
  function automatic logic [31:0] gf_mod(input logic [63:0] v);
    logic [63:0] r;
    r = v;
    for (int i = 63; i >= 32; i--) begin
      if (r[i]) r = r ^ ({31'h0, 1'b1, CRC32_POLY} << (i - 32));
    end
    return r[31:0];
  endfunction

  function automatic logic [31:0] model_word(input logic [31:0] c, input logic [31:0] d);
    return gf_mod({c ^ d, 32'h0});
  endfunction

  function automatic logic [31:0] model_byte(input logic [31:0] c, input logic [7:0] b);
    return {c[23:0], 8'h0} ^ gf_mod({24'h0, c[31:24] ^ b, 32'h0});
  endfunction

  task automatic add_pkt(input logic [31:0] hdr, input logic [31:0] flip);
    logic [31:0] c;
    int          len;
    len = int'(hdr[6:0]);
    c = model_word(CRC32_INIT, hdr);
    stim_q.push_back('{hdr, 1'b0, 1'b0});
    exp_fwd.push_back('{hdr, len == 0});
    for (int k = 0; k < len; k++) begin
      c = model_word(c, pay_q[k]);
      stim_q.push_back('{pay_q[k], 1'b0, 1'b0});
      exp_fwd.push_back('{pay_q[k], k == len - 1});
    end
    stim_q.push_back('{c ^ flip, 1'b1, flip == 32'h0});
    pay_q.delete();
  endtask

  task automatic rand_pkt(input int len, input bit bad);
    logic [31:0] hdr;
    hdr = $urandom();
    hdr[6:0] = 7'(len);
    for (int k = 0; k < len; k++) pay_q.push_back($urandom());
    add_pkt(hdr, bad ? (32'h1 << $urandom_range(31)) : 32'h0);
  endtask

  // One clock: check outputs at negedge against the model, then advance the model.
  task automatic cycle();
    bit    have, trl, exp_rdy, hs;
    word_t cur;
    fwd_t  e;
    have = (stim_q.size() > 0);
    if (have) cur = stim_q[0];
    trl = have && cur.trailer;
    @(negedge clk);
    check_eq("crc_valid", 32'(crc_valid), 32'(pend_good));
    check_eq("crc_error", 32'(crc_error), 32'(pend_bad));
    exp_rdy = trl ? 1'b1 : out_bus.ready;
    check_eq("in_ready", 32'(in_bus.ready), 32'(exp_rdy));
    check_eq("out_valid", 32'(out_bus.valid), 32'(in_bus.valid && !trl));
    hs = in_bus.valid && exp_rdy;
    if (in_bus.valid && !trl && out_bus.ready) begin
      if (exp_fwd.size() == 0) begin
        check_eq("fwd_extra", 32'h1, 32'h0);
      end else begin
        e = exp_fwd.pop_front();
        check_eq("out_data", out_bus.data, e.data);
        check_eq("out_last", 32'(out_last), 32'(e.last));
      end
    end
    @(posedge clk);
    pend_good = 1'b0;
    pend_bad  = 1'b0;
    if (hs) begin
      void'(stim_q.pop_front());
      if (trl) begin
        pend_good = cur.good;
        pend_bad  = !cur.good;
      end
    end
    if (cnt_clear) begin
      m_pkt = '0;
      m_err = '0;
    end else if (hs && trl) begin
      if (m_pkt != 16'hFFFF) m_pkt = m_pkt + 16'd1;
      if (!cur.good && m_err != 16'hFFFF) m_err = m_err + 16'd1;
    end
    #1;
  endtask

  task automatic run_stream(input int gap_pct, input int stall_pct, input int stall_idx,
                            input int stall_len, input bit clr, output int ncyc);
    int widx, left, budget, sz;
    widx = 0; left = stall_len; budget = 0; ncyc = 0;
    while (stim_q.size() > 0 && budget < 5000) begin
      budget++;
      in_bus.data  = stim_q[0].data;
      in_bus.valid = ($urandom_range(99) < gap_pct) ? 1'b0 : 1'b1;
      if (widx == stall_idx && left > 0) begin
        out_bus.ready = 1'b0;
        left--;
      end else begin
        out_bus.ready = ($urandom_range(99) < stall_pct) ? 1'b0 : 1'b1;
      end
      cnt_clear = clr && stim_q[0].trailer;
      sz = stim_q.size();
      cycle();
      if (stim_q.size() != sz) widx++;
      ncyc++;
    end
    check_eq("stream_left", 32'(stim_q.size()), 32'h0);
    stim_q.delete();
    in_bus.valid = 1'b0;
    cnt_clear = 1'b0;
    out_bus.ready = 1'b1;
    cycle();
    cycle();
    check_eq("fwd_left", 32'(exp_fwd.size()), 32'h0);
    exp_fwd.delete();
  endtask

  task automatic check_counts(input string tag);
    check_eq({tag, "_pkt"}, 32'(pkt_count), 32'(m_pkt));
    check_eq({tag, "_err"}, 32'(err_count), 32'(m_err));
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] c;
    int          ncyc;
    in_bus.valid = 1'b0;
    in_bus.data = '0;
    out_bus.ready = 1'b0;

    c = CRC32_INIT;
    for (int k = 0; k < 9; k++) c = model_byte(c, 8'(8'h31 + k));
    check_eq("golden_123456789", c, 32'h0376E6E7);

    for (int k = 0; k < 1000; k++) begin
      w_crc = $urandom();
      w_data = $urandom();
      #1;
      check_eq("crc32_word", w_out, model_word(w_crc, w_data));
    end

    #3;
    check_eq("rst_in_ready", 32'(in_bus.ready), 32'h0);
    check_eq("rst_out_valid", 32'(out_bus.valid), 32'h0);
    check_eq("rst_crc_valid", 32'(crc_valid), 32'h0);
    check_eq("rst_crc_error", 32'(crc_error), 32'h0);
    check_counts("rst");
    @(posedge clk); #1;
    n_rst = 1'b1;
    out_bus.ready = 1'b1;

    pay_q.push_back(32'hDEADBEEF);
    pay_q.push_back(32'h01234567);
    add_pkt(32'h00000002, 32'h0);
    run_stream(0, 0, -1, 0, 1'b0, ncyc);
    check_eq("good_cycles", 32'(ncyc), 32'd4);
    check_counts("good");

    pay_q.push_back(32'hDEADBEEF);
    pay_q.push_back(32'h01234567);
    add_pkt(32'h00000002, 32'h1);
    run_stream(0, 0, -1, 0, 1'b0, ncyc);
    check_counts("bad");

    add_pkt(32'h00000000, 32'h0);
    pay_q.push_back(32'hCAFEF00D);
    add_pkt(32'h00000001, 32'h0);
    run_stream(0, 0, -1, 0, 1'b0, ncyc);
    check_eq("no_bubble", 32'(ncyc), 32'd5);
    check_counts("zero_len");

    rand_pkt(3, 1'b0);
    run_stream(0, 0, 2, 5, 1'b0, ncyc);
    check_eq("stall_cycles", 32'(ncyc), 32'd10);
    check_counts("stall");

    stim_q.push_back('{32'h00000003, 1'b0, 1'b0});
    stim_q.push_back('{32'h13579BDF, 1'b0, 1'b0});
    exp_fwd.push_back('{32'h00000003, 1'b0});
    exp_fwd.push_back('{32'h13579BDF, 1'b0});
    run_stream(0, 0, -1, 0, 1'b0, ncyc);
    n_rst = 1'b0;
    cycle();
    m_pkt = '0;
    m_err = '0;
    n_rst = 1'b1;
    cycle();
    check_counts("mid_reset");
    rand_pkt(2, 1'b0);
    run_stream(0, 0, -1, 0, 1'b0, ncyc);
    check_counts("after_reset");

    force dut.pkt_cnt = 16'hFFFF;
    force dut.err_cnt = 16'hFFFF;
    @(posedge clk); #1;
    release dut.pkt_cnt;
    release dut.err_cnt;
    m_pkt = 16'hFFFF;
    m_err = 16'hFFFF;
    rand_pkt(1, 1'b1);
    run_stream(0, 0, -1, 0, 1'b0, ncyc);
    check_counts("saturate");

    rand_pkt(2, 1'b1);
    run_stream(0, 0, -1, 0, 1'b1, ncyc);
    check_counts("clear_wins");

    rand_pkt(127, 1'b0);
    run_stream(0, 0, -1, 0, 1'b0, ncyc);
    for (int p = 0; p < 40; p++) rand_pkt($urandom_range(12), $urandom_range(3) == 0);
    run_stream(20, 25, -1, 0, 1'b0, ncyc);
    check_counts("random");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
